// File: rtl/vc_release_monitor_pkg.sv
// Shared types and sizing helpers for the per-input-port VC release monitor.
package vc_release_monitor_pkg;

  // Defaults shared with the input buffer so both sides agree on VC depth.
  localparam int VC_NUM_DEFAULT      = 4;
  localparam int BUFFER_SIZE_DEFAULT = 8;

  // Packet lifecycle of one virtual channel.
  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ACTIVE = 2'd1,
    VC_DRAIN  = 2'd2
  } vc_life_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Select width for n channels, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_release_monitor_lifecycle_fsm.sv
// Lifecycle tracker for one virtual channel: state, flit count,
// one-cycle release pulse and sticky protocol-error flag.
module vc_release_monitor_lifecycle_fsm
  import vc_release_monitor_pkg::*;
#(
  parameter  int BUFFER_SIZE = BUFFER_SIZE_DEFAULT,
  localparam int CNT_W       = cnt_width(BUFFER_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic             i_head,
  input  logic             i_tail,
  input  logic             i_rd,
  output logic             o_release,
  output logic             o_idle,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_error
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

  vc_life_t         r_state;
  vc_life_t         w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_release;
  logic             w_release_nxt;
  logic             r_idle;
  logic             r_error;
  logic             w_error_nxt;
  logic             w_proto_ok;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Decide which of this cycle's write/read are accepted; anything refused raises the sticky error.
  always_comb begin
    w_proto_ok = 1'b0;
    case (r_state)
      VC_IDLE:   w_proto_ok = i_head;
      VC_ACTIVE: w_proto_ok = ~i_head;
      default:   w_proto_ok = 1'b0;
    endcase
    // A full buffer still accepts a write when a flit leaves in the same cycle,
    // and an empty buffer still services a read when a flit bypasses it.
    w_wr_acc    = i_wr & w_proto_ok & ((r_cnt < FULL) | i_rd);
    w_rd_acc    = i_rd & ((r_cnt != '0) | w_wr_acc);
    w_error_nxt = r_error | (i_wr & ~w_wr_acc) | (i_rd & ~w_rd_acc);
  end

  // Advance the lifecycle; a packet whose tail is in and whose buffer empties releases the VC.
  always_comb begin
    w_cnt_nxt     = r_cnt + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
    w_state_nxt   = r_state;
    w_release_nxt = 1'b0;
    case (r_state)
      VC_IDLE:   if (w_wr_acc) w_state_nxt = i_tail ? VC_DRAIN : VC_ACTIVE;
      VC_ACTIVE: if (w_wr_acc && i_tail) w_state_nxt = VC_DRAIN;
      VC_DRAIN:  w_state_nxt = VC_DRAIN;
      default:   w_state_nxt = VC_IDLE;
    endcase
    // Checked on the post-transition state so a HEADTAIL bypass releases immediately.
    if (w_state_nxt == VC_DRAIN && w_cnt_nxt == '0) begin
      w_state_nxt   = VC_IDLE;
      w_release_nxt = 1'b1;
    end
  end

  // State and registered outputs; reset returns to IDLE without emitting a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= VC_IDLE;
      r_cnt     <= '0;
      r_release <= 1'b0;
      r_idle    <= 1'b1;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_release <= w_release_nxt;
      r_idle    <= (w_state_nxt == VC_IDLE);
      r_error   <= w_error_nxt;
    end
  end

  assign o_release = r_release;
  assign o_idle    = r_idle;
  assign o_cnt     = r_cnt;
  assign o_error   = r_error;

endmodule

// File: rtl/vc_release_monitor.sv
// Downstream VC release monitor for one router input port: decodes the
// written flit's VC into per-VC strobes and runs one lifecycle tracker per VC.
module vc_release_monitor
  import vc_release_monitor_pkg::*;
#(
  parameter  int VC_NUM      = VC_NUM_DEFAULT,
  parameter  int BUFFER_SIZE = BUFFER_SIZE_DEFAULT,
  localparam int VC_SIZE     = sel_width(VC_NUM),
  localparam int CNT_W       = cnt_width(BUFFER_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flit_valid_i,
  input  logic [VC_SIZE-1:0]            flit_vc_i,
  input  logic                          flit_is_head_i,
  input  logic                          flit_is_tail_i,
  input  logic [VC_NUM-1:0]             read_i,
  output logic [VC_NUM-1:0]             vc_release_o,
  output logic [VC_NUM-1:0]             vc_idle_o,
  output logic [VC_NUM-1:0][CNT_W-1:0]  occupancy_o,
  output logic [VC_NUM-1:0]             error_o
);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic w_wr;

    // Out-of-range VC indices match no channel and are silently dropped.
    assign w_wr = flit_valid_i && (flit_vc_i == VC_SIZE'(v));

    vc_release_monitor_lifecycle_fsm #(
      .BUFFER_SIZE (BUFFER_SIZE)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr),
      .i_head    (flit_is_head_i),
      .i_tail    (flit_is_tail_i),
      .i_rd      (read_i[v]),
      .o_release (vc_release_o[v]),
      .o_idle    (vc_idle_o[v]),
      .o_cnt     (occupancy_o[v]),
      .o_error   (error_o[v])
    );
  end

endmodule

// File: tb/tb_vc_release_monitor.sv
// Bench for vc_release_monitor: directed vector table, hand-written corner
// sequences, and randomized legal traffic checked against a reference model.
module tb_vc_release_monitor;

  localparam int VC_NUM = 4;
  localparam int BS     = 8;
  localparam int CNT_W  = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flit_valid_i;
  logic [1:0]                   flit_vc_i;
  logic                         flit_is_head_i;
  logic                         flit_is_tail_i;
  logic [VC_NUM-1:0]            read_i;
  logic [VC_NUM-1:0]            vc_release_o;
  logic [VC_NUM-1:0]            vc_idle_o;
  logic [VC_NUM-1:0][CNT_W-1:0] occupancy_o;
  logic [VC_NUM-1:0]            error_o;

  vc_release_monitor #(
    .VC_NUM      (VC_NUM),
    .BUFFER_SIZE (BS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_valid_i   (flit_valid_i),
    .flit_vc_i      (flit_vc_i),
    .flit_is_head_i (flit_is_head_i),
    .flit_is_tail_i (flit_is_tail_i),
    .read_i         (read_i),
    .vc_release_o   (vc_release_o),
    .vc_idle_o      (vc_idle_o),
    .occupancy_o    (occupancy_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-VC flit count, "packet open" (head seen, tail not yet)
  // and "awaiting drain" (tail seen, flits still buffered).
  int m_cnt   [VC_NUM];
  bit m_open  [VC_NUM];
  bit m_drain [VC_NUM];
  bit m_err   [VC_NUM];
  bit m_rel   [VC_NUM];

  // Scoreboard for the random phase.
  bit armed [VC_NUM];
  int pkts  [VC_NUM];
  int rels  [VC_NUM];

  typedef struct {
    logic        valid;
    logic [1:0]  vc;
    logic        head;
    logic        tail;
    logic [3:0]  rd;
    logic [15:0] e_occ;
    logic [3:0]  e_idle;
    logic [3:0]  e_rel;
    logic [3:0]  e_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [1:0] vc, input logic head,
                       input logic tail, input logic [3:0] rd);
    flit_valid_i   = valid;
    flit_vc_i      = vc;
    flit_is_head_i = head;
    flit_is_tail_i = tail;
    read_i         = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int v = 0; v < VC_NUM; v++) begin
      m_cnt[v] = 0; m_open[v] = 0; m_drain[v] = 0; m_err[v] = 0; m_rel[v] = 0;
      armed[v] = 0; pkts[v] = 0; rels[v] = 0;
    end
  endtask

  task automatic model_step(input logic valid, input logic [1:0] vc, input logic head,
                            input logic tail, input logic [3:0] rd);
    for (int v = 0; v < VC_NUM; v++) begin
      bit wr, r, legal, wa, ra;
      wr = valid && (int'(vc) == v);
      r  = rd[v];
      if (m_drain[v])     legal = 1'b0;
      else if (m_open[v]) legal = !head;
      else                legal = head;
      wa = wr && legal && (m_cnt[v] < BS || r);
      ra = r && (m_cnt[v] > 0 || wa);
      if ((wr && !wa) || (r && !ra)) m_err[v] = 1'b1;
      m_cnt[v] = m_cnt[v] + int'(wa) - int'(ra);
      if (wa && tail) begin
        m_open[v]  = 1'b0;
        m_drain[v] = 1'b1;
      end else if (wa && head) begin
        m_open[v] = 1'b1;
      end
      m_rel[v] = 1'b0;
      if (m_drain[v] && m_cnt[v] == 0) begin
        m_drain[v] = 1'b0;
        m_rel[v]   = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] e_occ;
    logic [3:0]  e_idle, e_rel, e_err;
    for (int v = 0; v < VC_NUM; v++) begin
      e_occ[v*4 +: 4] = 4'(m_cnt[v]);
      e_idle[v]       = !m_open[v] && !m_drain[v];
      e_rel[v]        = m_rel[v];
      e_err[v]        = m_err[v];
    end
    chk({tag, "_occ"},  occupancy_o,  e_occ);
    chk({tag, "_idle"}, vc_idle_o,    e_idle);
    chk({tag, "_rel"},  vc_release_o, e_rel);
    chk({tag, "_err"},  error_o,      e_err);
  endtask

  task automatic check_all(input string tag, input logic [15:0] occ, input logic [3:0] idle,
                           input logic [3:0] rel, input logic [3:0] err);
    chk({tag, "_occ"},  occupancy_o,  occ);
    chk({tag, "_idle"}, vc_idle_o,    idle);
    chk({tag, "_rel"},  vc_release_o, rel);
    chk({tag, "_err"},  error_o,      err);
  endtask

  task automatic scoreboard();
    for (int v = 0; v < VC_NUM; v++) begin
      if (vc_release_o[v]) begin
        chk($sformatf("rnd_release_has_head_vc%0d", v), 32'(armed[v]), 32'd1);
        armed[v] = 1'b0;
        rels[v]++;
      end
    end
  endtask

  initial begin
    logic       valid, head, tail;
    logic [1:0] vc;
    logic [3:0] rd;
    int         all_idle_cycle;

    // VC1 packet of three flits, then three reads; VC0 HEADTAIL bypass; error cases.
    tbl[0]  = '{1'b1, 2'd1, 1'b1, 1'b0, 4'h0, 16'h0010, 4'hD, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 4'h0, 16'h0020, 4'hD, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 4'h0, 16'h0030, 4'hD, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h2, 16'h0020, 4'hD, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h2, 16'h0010, 4'hD, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h2, 16'h0000, 4'hF, 4'h2, 4'h0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 16'h0000, 4'hF, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 2'd0, 1'b1, 1'b1, 4'h1, 16'h0000, 4'hF, 4'h1, 4'h0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 16'h0000, 4'hF, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 1'b0, 4'h0, 16'h0000, 4'hF, 4'h0, 4'h8};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h1, 16'h0000, 4'hF, 4'h0, 4'h9};

    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 4'hF, 4'h0, 4'h0);
    rst = 1'b0;
    tick();
    check_all("post_reset", 16'h0000, 4'hF, 4'h0, 4'h0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].valid, tbl[i].vc, tbl[i].head, tbl[i].tail, tbl[i].rd);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_occ, tbl[i].e_idle, tbl[i].e_rel, tbl[i].e_err);
    end

    // Fill VC2 to capacity: head then seven bodies.
    drive(1'b1, 2'd2, 1'b1, 1'b0, 4'h0);
    tick();
    chk("fill_occ1", occupancy_o, 16'h0100);
    for (int k = 2; k <= BS; k++) begin
      drive(1'b1, 2'd2, 1'b0, 1'b0, 4'h0);
      tick();
      chk($sformatf("fill_occ%0d", k), occupancy_o, 32'(k) << 8);
    end
    // Write into a full buffer is refused.
    drive(1'b1, 2'd2, 1'b0, 1'b0, 4'h0);
    tick();
    check_all("overflow", 16'h0800, 4'hB, 4'h0, 4'hD);
    // Write with simultaneous read at full is accepted, count unchanged.
    drive(1'b1, 2'd2, 1'b0, 1'b0, 4'h4);
    tick();
    check_all("full_wr_rd", 16'h0800, 4'hB, 4'h0, 4'hD);

    // Reset while VC2 is mid-packet: immediate clear, no release pulse.
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    #2;
    check_all("async_rst", 16'h0000, 4'hF, 4'h0, 4'h0);
    tick();
    chk("rst_hold_rel", vc_release_o, 4'h0);
    rst = 1'b0;
    tick();
    check_all("rst_exit", 16'h0000, 4'hF, 4'h0, 4'h0);

    // Randomized legal traffic on all VCs.
    model_reset();
    for (int c = 0; c < 400; c++) begin
      valid = 1'b0; head = 1'b0; tail = 1'b0; rd = 4'h0;
      vc = 2'($urandom_range(3));
      if ($urandom_range(3) != 0 && !m_drain[vc]) begin
        valid = 1'b1;
        if (!m_open[vc]) head = 1'b1;
        tail = ($urandom_range(3) == 0);
      end
      for (int v = 0; v < VC_NUM; v++)
        if (m_cnt[v] > 0 && $urandom_range(1) == 1) rd[v] = 1'b1;
      if (valid && m_cnt[vc] == 0 && $urandom_range(3) == 0) rd[vc] = 1'b1;
      if (valid && m_cnt[vc] >= BS) rd[vc] = 1'b1;
      if (valid && head) begin
        pkts[vc]++;
        armed[vc] = 1'b1;
      end
      drive(valid, vc, head, tail, rd);
      model_step(valid, vc, head, tail, rd);
      tick();
      check_model("rnd");
      scoreboard();
    end

    // Close every open packet and drain all buffers, bounded.
    all_idle_cycle = -1;
    for (int c = 0; c < 300; c++) begin
      bit any_busy;
      any_busy = 1'b0;
      for (int v = 0; v < VC_NUM; v++)
        if (m_open[v] || m_drain[v]) any_busy = 1'b1;
      if (!any_busy) begin
        all_idle_cycle = c;
        break;
      end
      valid = 1'b0; head = 1'b0; tail = 1'b0; vc = 2'd0; rd = 4'h0;
      for (int v = VC_NUM - 1; v >= 0; v--)
        if (m_open[v]) begin
          valid = 1'b1; tail = 1'b1; vc = 2'(v);
        end
      for (int v = 0; v < VC_NUM; v++)
        if (m_cnt[v] > 0) rd[v] = 1'b1;
      drive(valid, vc, head, tail, rd);
      model_step(valid, vc, head, tail, rd);
      tick();
      check_model("drain");
      scoreboard();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
    chk("drain_completed", 32'(all_idle_cycle >= 0), 32'd1);
    chk("final_idle", vc_idle_o, 4'hF);
    chk("final_err", error_o, 4'h0);
    for (int v = 0; v < VC_NUM; v++)
      chk($sformatf("release_count_vc%0d", v), 32'(rels[v]), 32'(pkts[v]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
